// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer_pkg
// Description : Shared definitions for the fetch sequencer and its decoder
//               neighbour: sequencer state encoding, instruction field
//               positions and the operand-consumption predicate.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_sequencer_pkg;

   // Sequencer phases
   typedef enum logic [1:0] {
      FETCH = 2'b00,
      EXEC  = 2'b01,
      HALT  = 2'b10
   } state_t;

   // Instruction field positions (shared with the decoder)
   localparam int         c_SRC_MSB = 5;
   localparam int         c_SRC_LSB = 4;
   localparam int         c_IDX_BIT = 0;
   localparam logic [1:0] c_SRC_MEM = 2'b00;

   // An instruction consumes the ROM byte after its opcode when it reads
   // memory in immediate (non-indexed) form.
   function automatic logic operand_used(input logic [7:0] ir);
      return (ir[c_SRC_MSB:c_SRC_LSB] == c_SRC_MEM) && !ir[c_IDX_BIT];
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_pc_counter.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer_pc_counter
// Description : PC_WIDTH-bit program counter register. Asynchronous
//               active-low reset to RESET_PC, synchronous load and
//               increment; load has priority over increment. Increment
//               wraps modulo 2^PC_WIDTH.
// Ports       : clk        - system clock
//               resetBar   - asynchronous active-low reset
//               i_load     - load i_load_val this edge
//               i_inc      - increment this edge (ignored when i_load)
//               i_load_val - load value
//               o_pc       - current counter value
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer_pc_counter #(
   parameter int PC_WIDTH = 8,
   parameter int RESET_PC = 0
) (
   input  logic                clk,
   input  logic                resetBar,
   input  logic                i_load,
   input  logic                i_inc,
   input  logic [PC_WIDTH-1:0] i_load_val,
   output logic [PC_WIDTH-1:0] o_pc
);

   localparam logic [PC_WIDTH-1:0] c_RESET_PC = PC_WIDTH'(RESET_PC);
   localparam logic [PC_WIDTH-1:0] c_ONE      = PC_WIDTH'(1);

   logic [PC_WIDTH-1:0] r_pc;

   always_ff @(posedge clk or negedge resetBar) begin
      if (!resetBar) begin
         r_pc <= c_RESET_PC;
      end else if (i_load) begin
         r_pc <= i_load_val;
      end else if (i_inc) begin
         r_pc <= r_pc + c_ONE;
      end
   end

   assign o_pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Owns the program counter, instruction register and the
//               A-derived flags. Sequences every instruction through one
//               FETCH cycle and one EXEC cycle; a jump to the address of
//               the executing opcode enters HALT until reset.
// Ports       : clk       - system clock
//               resetBar  - asynchronous active-low reset
//               romData   - program ROM byte at romAddr
//               dbus      - data bus (jump target) in EXEC
//               doJump    - decoder jump decision (EXEC only)
//               loadA     - A written this EXEC cycle
//               aluCarry  - carry of value written to A
//               aluZero   - value written to A is zero
//               romAddr   - current PC
//               ir        - instruction register
//               flagCarry - registered carry flag
//               aIsZero   - registered zero flag of A
//               execPhase - high in EXEC
//               halted    - high after a jump-to-self
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int PC_WIDTH = 8,
   parameter int RESET_PC = 0
) (
   input  logic                clk,
   input  logic                resetBar,
   input  logic [7:0]          romData,
   input  logic [7:0]          dbus,
   input  logic                doJump,
   input  logic                loadA,
   input  logic                aluCarry,
   input  logic                aluZero,
   output logic [PC_WIDTH-1:0] romAddr,
   output logic [7:0]          ir,
   output logic                flagCarry,
   output logic                aIsZero,
   output logic                execPhase,
   output logic                halted
);

   localparam logic [PC_WIDTH-1:0] c_ONE = PC_WIDTH'(1);

   state_t              r_state;
   logic [7:0]          r_ir;
   logic                r_carry;
   logic                r_zero;
   logic                r_exec;
   logic                r_halted;

   logic [PC_WIDTH-1:0] w_pc;
   logic [PC_WIDTH-1:0] w_pc_m1;
   logic [PC_WIDTH-1:0] w_dbus_pc;
   logic                w_in_exec;
   logic                w_in_fetch;
   logic                w_operand;
   logic                w_load;
   logic                w_inc;
   logic                w_self_jump;

   assign w_in_exec  = (r_state == EXEC);
   assign w_in_fetch = (r_state == FETCH);
   assign w_operand  = operand_used(r_ir);
   assign w_dbus_pc  = PC_WIDTH'(dbus);

   // During EXEC the PC already points one past the opcode, so the opcode
   // address is pc-1 (wrapping at zero).
   assign w_pc_m1     = w_pc - c_ONE;
   assign w_self_jump = w_in_exec && doJump && (w_dbus_pc == w_pc_m1);

   // A jump replaces the operand skip; it never adds an extra increment.
   assign w_load = w_in_exec && doJump;
   assign w_inc  = w_in_fetch || (w_in_exec && !doJump && w_operand);

   fetch_sequencer_pc_counter #(
      .PC_WIDTH (PC_WIDTH),
      .RESET_PC (RESET_PC)
   ) u_pc_counter (
      .clk        (clk),
      .resetBar   (resetBar),
      .i_load     (w_load),
      .i_inc      (w_inc),
      .i_load_val (w_dbus_pc),
      .o_pc       (w_pc)
   );

   always_ff @(posedge clk or negedge resetBar) begin
      if (!resetBar) begin
         r_state  <= FETCH;
         r_ir     <= 8'h00;
         r_carry  <= 1'b0;
         r_zero   <= 1'b1;
         r_exec   <= 1'b0;
         r_halted <= 1'b0;
      end else begin
         case (r_state)
            FETCH: begin
               r_ir    <= romData;
               r_state <= EXEC;
               r_exec  <= 1'b1;
            end
            EXEC: begin
               // Flag update is independent of the jump decision.
               if (loadA) begin
                  r_carry <= aluCarry;
                  r_zero  <= aluZero;
               end
               r_exec <= 1'b0;
               if (w_self_jump) begin
                  r_halted <= 1'b1;
                  r_state  <= HALT;
               end else begin
                  r_state <= FETCH;
               end
            end
            HALT: begin
               r_state <= HALT;
            end
            default: begin
               r_state <= FETCH;
               r_exec  <= 1'b0;
            end
         endcase
      end
   end

   assign romAddr   = w_pc;
   assign ir        = r_ir;
   assign flagCarry = r_carry;
   assign aIsZero   = r_zero;
   assign execPhase = r_exec;
   assign halted    = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Directed self-checking bench for fetch_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

   logic       clk;
   logic       resetBar;
   logic [7:0] romData;
   logic [7:0] dbus;
   logic       doJump;
   logic       loadA;
   logic       aluCarry;
   logic       aluZero;
   logic [7:0] romAddr;
   logic [7:0] ir;
   logic       flagCarry;
   logic       aIsZero;
   logic       execPhase;
   logic       halted;

   logic [7:0] rom [256];
   int         n_tests;
   int         n_fail;
   logic       exp_c;
   logic       exp_z;

   fetch_sequencer #(
      .PC_WIDTH (8),
      .RESET_PC (0)
   ) dut (
      .clk       (clk),
      .resetBar  (resetBar),
      .romData   (romData),
      .dbus      (dbus),
      .doJump    (doJump),
      .loadA     (loadA),
      .aluCarry  (aluCarry),
      .aluZero   (aluZero),
      .romAddr   (romAddr),
      .ir        (ir),
      .flagCarry (flagCarry),
      .aIsZero   (aIsZero),
      .execPhase (execPhase),
      .halted    (halted)
   );

   assign romData = rom[romAddr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // FETCH with noisy non-ROM inputs, which must be ignored.
   task automatic do_fetch(input string tag, input logic [7:0] e_ir, input logic [7:0] e_pc);
      doJump = 1'b1; dbus = 8'h77; loadA = 1'b1; aluCarry = ~exp_c; aluZero = ~exp_z;
      tick();
      chk({tag, ".ir"}, ir, e_ir);
      chk({tag, ".pc"}, romAddr, e_pc);
      chk({tag, ".exec"}, execPhase, 1'b1);
      chk({tag, ".c"}, flagCarry, exp_c);
      chk({tag, ".z"}, aIsZero, exp_z);
   endtask

   task automatic do_exec(input string tag, input logic j, input logic [7:0] db,
                          input logic la, input logic c, input logic z,
                          input logic [7:0] e_pc, input logic e_halt);
      doJump = j; dbus = db; loadA = la; aluCarry = c; aluZero = z;
      if (la) begin
         exp_c = c;
         exp_z = z;
      end
      tick();
      chk({tag, ".pc"}, romAddr, e_pc);
      chk({tag, ".exec"}, execPhase, 1'b0);
      chk({tag, ".halt"}, halted, e_halt);
      chk({tag, ".c"}, flagCarry, exp_c);
      chk({tag, ".z"}, aIsZero, exp_z);
   endtask

   initial begin
      n_tests = 0; n_fail = 0;
      exp_c = 1'b0; exp_z = 1'b1;
      for (int i = 0; i < 256; i++) rom[i] = 8'h31;   // source=11: no operand
      rom[8'h00] = 8'h0D;                              // indexed: no operand
      rom[8'h01] = 8'h08;                              // immediate memory
      rom[8'h02] = 8'hAA;                              // operand byte
      rom[8'h10] = 8'h08;
      rom[8'h11] = 8'hBB;

      resetBar = 1'b0; doJump = 1'b0; dbus = 8'h00; loadA = 1'b0;
      aluCarry = 1'b0; aluZero = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      chk("rst.pc", romAddr, 8'h00);
      chk("rst.ir", ir, 8'h00);
      chk("rst.c", flagCarry, 1'b0);
      chk("rst.z", aIsZero, 1'b1);
      chk("rst.halt", halted, 1'b0);
      chk("rst.exec", execPhase, 1'b0);
      resetBar = 1'b1;                                 // mid-cycle release

      do_fetch("f0", 8'h0D, 8'h01);
      do_exec ("e0", 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0);
      do_fetch("f1", 8'h08, 8'h02);
      do_exec ("e1", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h03, 1'b0);   // operand skipped, flags hold
      do_fetch("f3", 8'h31, 8'h04);
      do_exec ("e3", 1'b1, 8'h10, 1'b1, 1'b0, 1'b0, 8'h10, 1'b0);   // jump + loadA
      do_fetch("f10", 8'h08, 8'h11);
      do_exec ("e10j", 1'b1, 8'h40, 1'b1, 1'b1, 1'b0, 8'h40, 1'b0); // jump beats operand
      do_fetch("f40", 8'h31, 8'h41);
      do_exec ("e40", 1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0);
      do_fetch("f10b", 8'h08, 8'h11);
      do_exec ("e10n", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h12, 1'b0);
      do_fetch("f12", 8'h31, 8'h13);
      do_exec ("e12", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0);
      do_fetch("fFF", 8'h31, 8'h00);                                // wrap
      do_exec ("eFF", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      do_fetch("f00", 8'h0D, 8'h01);
      do_exec ("e00", 1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 8'h05, 1'b0);
      do_fetch("f05", 8'h31, 8'h06);
      do_exec ("e05", 1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 8'h05, 1'b1);  // jump-to-self

      doJump = 1'b1; dbus = 8'h20; loadA = 1'b1; aluCarry = 1'b0; aluZero = 1'b1;
      repeat (10) tick();
      chk("hlt.pc", romAddr, 8'h05);
      chk("hlt.ir", ir, 8'h31);
      chk("hlt.halt", halted, 1'b1);
      chk("hlt.exec", execPhase, 1'b0);
      chk("hlt.c", flagCarry, exp_c);
      chk("hlt.z", aIsZero, exp_z);

      // Leave HALT through reset, then reset again in the middle of EXEC.
      resetBar = 1'b0;
      #2;
      resetBar = 1'b1;
      exp_c = 1'b0; exp_z = 1'b1;
      do_fetch("rf0", 8'h0D, 8'h01);
      loadA = 1'b1; aluCarry = 1'b1; aluZero = 1'b0;
      #2;
      resetBar = 1'b0;
      #1;
      chk("mrst.pc", romAddr, 8'h00);
      chk("mrst.ir", ir, 8'h00);
      chk("mrst.exec", execPhase, 1'b0);
      chk("mrst.c", flagCarry, 1'b0);
      chk("mrst.z", aIsZero, 1'b1);
      chk("mrst.halt", halted, 1'b0);
      #1;
      resetBar = 1'b1;
      do_fetch("rf1", 8'h0D, 8'h01);
      do_exec ("re0", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0);
      do_fetch("rfFF", 8'h31, 8'h00);
      do_exec ("reFF", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1); // pc=0 matches 0xFF

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
